mem2axi: RTL
============

# mem2axi

Single-outstanding bridge from the core-side request/grant memory port to an AXI4 master port. It is the initiator counterpart of `axi2mem`. Each accepted memory request becomes exactly one single-beat AXI read or write, and its response is returned as a one-cycle `rvalid_o` pulse. It lets testharness-side agents (loaders, DMA-style stimulus, debug helpers) reach the crossbar slaves as an ordinary AXI master.

## Interface
- `AXI_ID_WIDTH`, default 10: ID width of the master port.
- `AXI_USER_WIDTH`, default 1: user width; user fields are driven to 0.
- `AXI_ADDR_WIDTH`, default 64: address width of `addr_i` and the AXI port.
- `AXI_DATA_WIDTH`, default 64: data width; must be 32 or 64.
- `AXI_ID`, default 0: constant ID driven on AW and AR.
- `clk_i  in  1`: clock. One clock domain only.
- `rst_i  in  1`: asynchronous, active-high reset.
- `req_i  in  1`: memory request valid.
- `we_i  in  1`: 1 = write, 0 = read.
- `addr_i  in  AXI_ADDR_WIDTH`: byte address.
- `be_i  in  AXI_DATA_WIDTH/8`: byte enables (writes only).
- `wdata_i  in  AXI_DATA_WIDTH`: write data.
- `gnt_o  out  1`: request accepted this cycle.
- `rvalid_o  out  1`: response pulse, one per granted request.
- `rdata_o  out  AXI_DATA_WIDTH`: read data, valid with `rvalid_o`.
- `err_o  out  1`: response error (`resp[1]` set), valid with `rvalid_o`.
- `master  AXI_BUS.Master  —`: AXI4 port. Widths follow the parameters.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- `gnt_o = req_i & (state == IDLE)`. This is combinational; no other source drives it.
- On grant, the block registers `we_i`, the address with its low `$clog2(AXI_DATA_WIDTH/8)` bits zeroed, `be_i` and `wdata_i`.
  - Next state is WR_REQ when `we_i` is 1, otherwise RD_ADDR.
- RD_ADDR:
  - `ar_valid=1`, `ar_addr` = registered address.
  - `ar_len=0`, `ar_size=$clog2(AXI_DATA_WIDTH/8)`, `ar_burst=INCR`.
  - `ar_id=AXI_ID`; lock, cache, prot, qos, region and user are 0.
  - On `ar_ready`, go to RD_DATA.
- RD_DATA:
  - `r_ready=1`.
  - On `r_valid`, capture `r_data` into `rdata_o` and `r_resp[1]` into `err_o`, set the `rvalid_o` register, and go to IDLE.
  - `r_last` and `r_id` are not checked.
- WR_REQ:
  - `aw_valid` and `w_valid` are both raised on entry. AW fields match the AR fields.
  - `w_strb` = registered `be_i`, `w_last=1`.
  - Each valid drops independently after its own handshake, tracked by `aw_done` and `w_done` flags.
  - When both have completed (including both in the same cycle), go to WR_RESP.
- WR_RESP:
  - `b_ready=1`.
  - On `b_valid`: `err_o = b_resp[1]`, `rvalid_o` set, `rdata_o` unchanged, go to IDLE.
- `rvalid_o` is a registered one-cycle pulse in the first IDLE cycle after the response handshake. A new grant is allowed in that same cycle.
- Unused ready/valid signals are held at 0 in every state. In particular, `r_ready=0` and `b_ready=0` outside RD_DATA and WR_RESP.
- Reset mid-transaction:
  - All valids and readies drop asynchronously, state returns to IDLE, and no `rvalid_o` is produced.
  - The downstream slave must be reset together with this block.

## Timing
- Reset values:
  - `gnt_o`, `rvalid_o`, `err_o` = 0; `rdata_o` = 0.
  - All AXI valid/ready outputs = 0; state = IDLE; `aw_done` = `w_done` = 0.
- Zero-wait read:
  - Grant at cycle 0, `ar_valid` at cycle 1 (with `ar_ready`=1).
  - `r_valid` at cycle 2, `rvalid_o` at cycle 3.
  - Minimum read latency is 3 cycles from grant to `rvalid_o`.
- Zero-wait write:
  - AW/W valid at cycle 1, `b_valid` at cycle 2, `rvalid_o` at cycle 3.
- Back-to-back throughput is at most one request per 3 cycles. A request held during a busy state sees `gnt_o=0` until IDLE.
- AXI rules: once asserted, a valid is held until its handshake, with fields stable. Valid never depends combinationally on ready.

## Test plan
- Read hit: `addr_i=0x8000_0008`, slave returns `r_data=0xDEAD_BEEF_0123_4567` with `resp=OKAY` → `ar_addr=0x8000_0008`, `ar_len=0`, `ar_size=3`; `rvalid_o` at cycle 3 with the same data and `err_o=0`.
- Write with strobes: `addr_i=0x8000_0013`, `be_i=0x0F`, `wdata_i=0x1122_3344_5566_7788` → `aw_addr=0x8000_0010`, `w_strb=0x0F`, `w_last=1`; one `rvalid_o` pulse after B.
- Split AW/W readiness: `aw_ready` asserted 4 cycles before `w_ready` → `aw_valid` drops after its handshake, `w_valid` is held until its own, B is accepted once, exactly one `rvalid_o`.
- Backpressure and error: `ar_ready` low for 5 cycles, then `r_resp=SLVERR` → `ar_valid` and `ar_addr` stable throughout; `rvalid_o=1` with `err_o=1`. A subsequent `b_resp=DECERR` also gives `err_o=1`.
- Back-to-back: `req_i` held high for 3 reads → `gnt_o` pulses at cycles 0, 3 and 6, each in the same cycle as the previous `rvalid_o`; responses return in order.
- Reset in RD_DATA: `rst_i` pulsed while waiting for `r_valid` → `r_ready`, `rvalid_o` and `gnt_o` go to 0 immediately; the next request after reset completes normally.

Source files
------------

// File: rtl/mem2axi_if.sv
// AXI4 bus bundle shared by the mem2axi master port and its slave-side peer.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/mem2axi.sv
// Single-outstanding bridge from a req/gnt memory port to an AXI4 master:
// every grant becomes one single-beat read or write, answered by a one-cycle rvalid_o.
module mem2axi #(
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    AXI_BUS.Master                      master
);
    localparam int unsigned OFFS = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFFS_MASK = AXI_ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [2:0]                  state;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH/8-1:0] be_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic                        aw_done;
    logic                        w_done;
    logic                        aw_done_next;
    logic                        w_done_next;

    // Gated by reset so a request presented during reset is never granted and lost.
    assign gnt_o = req_i & (state == IDLE) & ~rst_i;

    assign aw_done_next = aw_done | master.aw_ready;
    assign w_done_next  = w_done | master.w_ready;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // branch sees the pre-edge values; the datapath is reset too so outputs are defined.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i & ~OFFS_MASK;
                        be_q    <= be_i;
                        wdata_q <= wdata_i;
                        state   <= we_i ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (master.ar_ready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (master.r_valid) begin
                        rdata_o  <= master.r_data;
                        err_o    <= master.r_resp[1];
                        rvalid_o <= 1'b1;
                        state    <= IDLE;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; leave once both have handshaken.
                    if (aw_done_next && w_done_next) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        aw_done <= aw_done_next;
                        w_done  <= w_done_next;
                    end
                end
                WR_RESP: begin
                    if (master.b_valid) begin
                        err_o    <= master.b_resp[1];
                        rvalid_o <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = 3'(OFFS);
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = (state == WR_REQ) & ~aw_done;

    assign master.w_data    = wdata_q;
    assign master.w_strb    = be_q;
    assign master.w_last    = 1'b1;
    assign master.w_user    = '0;
    assign master.w_valid   = (state == WR_REQ) & ~w_done;

    assign master.b_ready   = (state == WR_RESP);

    assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = 3'(OFFS);
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = (state == RD_ADDR);

    assign master.r_ready   = (state == RD_DATA);

    // Response IDs, users, r_last and the low resp bit carry no meaning for a single-beat master.
    logic unused_resp;
    assign unused_resp = ^{master.b_id, master.b_user, master.b_resp[0],
                           master.r_id, master.r_user, master.r_last, master.r_resp[0]};
endmodule
